// File: rtl/pe_loader_pkg.sv
// Shared widths and helpers for the PE load initiator.
package pe_loader_pkg;

    localparam int INST_WIDTH = 32;
    localparam int DATA_WIDTH = 16;
    localparam int CPLX_WIDTH = DATA_WIDTH * 2;

    // Saturate a requested transfer count at the buffer depth.
    function automatic int unsigned clamp_cnt(input int unsigned cnt, input int unsigned limit);
        return (cnt > limit) ? limit : cnt;
    endfunction

endpackage

// File: rtl/pe_loader_buf.sv
// Small register file: synchronous write, combinational read, storage not reset.
module pe_loader_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage update; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pe_loader.sv
// PE load initiator: streams preloaded instructions, waits a fixed gap,
// then streams preloaded complex data words into one PE.
module pe_loader
    import pe_loader_pkg::*;
#(
    parameter int INST_DEPTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int GAP_CYCLES = 2,
    parameter int IAW        = $clog2(INST_DEPTH),
    parameter int DAW        = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_wr_en,
    input  logic [IAW-1:0]        inst_wr_addr,
    input  logic [INST_WIDTH-1:0] inst_wr_data,
    input  logic                  data_wr_en,
    input  logic [DAW-1:0]        data_wr_addr,
    input  logic [CPLX_WIDTH-1:0] data_wr_data,
    input  logic                  start,
    input  logic [IAW:0]          inst_cnt,
    input  logic [DAW:0]          data_cnt,
    output logic                  inst_out_v,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  dout_pe_v,
    output logic [CPLX_WIDTH-1:0] dout_pe,
    output logic                  busy,
    output logic                  done
);

    // state | meaning
    // IDLE  | waiting for start, buffers writable
    // INST  | one instruction word presented per cycle
    // GAP   | idle gap between instructions and data (down-counter)
    // DATA  | one data word presented per cycle
    // FIN   | done pulse, busy low, back to IDLE next cycle
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INST = 3'd1,
        GAP  = 3'd2,
        DATA = 3'd3,
        FIN  = 3'd4
    } state_e;

    localparam int XW = ((IAW > DAW) ? IAW : DAW) + 1;
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    state_e                state_q, state_d;
    logic [XW-1:0]         idx_q, idx_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [IAW:0]          n_q, n_d;
    logic [DAW:0]          m_q, m_d;
    logic                  inst_v_q, inst_v_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  data_v_q, data_v_d;
    logic [CPLX_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [IAW:0]          start_n;
    logic [DAW:0]          start_m;
    logic                  inst_wr_ok, data_wr_ok;
    logic [IAW-1:0]        inst_rd_addr;
    logic [DAW-1:0]        data_rd_addr;
    logic [INST_WIDTH-1:0] inst_rd_data, inst_word;
    logic [CPLX_WIDTH-1:0] data_rd_data, data_word;
    logic                  to_inst, to_gap, to_data, to_fin;

    assign start_n = (IAW+1)'(clamp_cnt(32'(inst_cnt), 32'(INST_DEPTH)));
    assign start_m = (DAW+1)'(clamp_cnt(32'(data_cnt), 32'(DATA_DEPTH)));

    // Host writes only land while no sequence is running.
    assign inst_wr_ok = inst_wr_en & ~busy_q;
    assign data_wr_ok = data_wr_en & ~busy_q;

    // The first word of each phase is fetched from entry 0 before the phase starts.
    assign inst_rd_addr = (state_q == INST) ? idx_q[IAW-1:0] : '0;
    assign data_rd_addr = (state_q == DATA) ? idx_q[DAW-1:0] : '0;

    // Forward a same-cycle write so a start coincident with a write streams the new value.
    assign inst_word = (inst_wr_ok && (inst_wr_addr == inst_rd_addr)) ? inst_wr_data : inst_rd_data;
    assign data_word = (data_wr_ok && (data_wr_addr == data_rd_addr)) ? data_wr_data : data_rd_data;

    pe_loader_buf #(
        .WIDTH (INST_WIDTH),
        .DEPTH (INST_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .wr_en   (inst_wr_ok),
        .wr_addr (inst_wr_addr),
        .wr_data (inst_wr_data),
        .rd_addr (inst_rd_addr),
        .rd_data (inst_rd_data)
    );

    pe_loader_buf #(
        .WIDTH (CPLX_WIDTH),
        .DEPTH (DATA_DEPTH)
    ) u_dbuf (
        .clk     (clk),
        .wr_en   (data_wr_ok),
        .wr_addr (data_wr_addr),
        .wr_data (data_wr_data),
        .rd_addr (data_rd_addr),
        .rd_data (data_rd_data)
    );

    // Next-state and next-output decode; every output is computed one cycle ahead.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        n_d      = n_q;
        m_d      = m_q;
        inst_v_d = 1'b0;
        inst_d   = '0;
        data_v_d = 1'b0;
        data_d   = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        to_inst  = 1'b0;
        to_gap   = 1'b0;
        to_data  = 1'b0;
        to_fin   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d = start_n;
                    m_d = start_m;
                    if (start_n != '0) begin
                        to_inst = 1'b1;
                    end else if (start_m != '0) begin
                        to_data = 1'b1;
                    end else begin
                        to_fin = 1'b1;
                    end
                end
            end
            INST: begin
                if (idx_q < XW'(n_q)) begin
                    to_inst = 1'b1;
                end else if (m_q == '0) begin
                    to_fin = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    to_gap = 1'b1;
                end else begin
                    to_data = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    to_data = 1'b1;
                end else begin
                    gap_d  = gap_q - GW'(1);
                    busy_d = 1'b1;
                end
            end
            DATA: begin
                if (idx_q < XW'(m_q)) begin
                    to_data = 1'b1;
                end else begin
                    to_fin = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (to_inst) begin
            state_d  = INST;
            busy_d   = 1'b1;
            inst_v_d = 1'b1;
            inst_d   = inst_word;
            idx_d    = (state_q == INST) ? idx_q + XW'(1) : XW'(1);
        end
        if (to_gap) begin
            state_d = GAP;
            busy_d  = 1'b1;
            gap_d   = GAP_LOAD;
            idx_d   = '0;
        end
        if (to_data) begin
            state_d  = DATA;
            busy_d   = 1'b1;
            data_v_d = 1'b1;
            data_d   = data_word;
            idx_d    = (state_q == DATA) ? idx_q + XW'(1) : XW'(1);
        end
        if (to_fin) begin
            state_d = FIN;
            done_d  = 1'b1;
            idx_d   = '0;
        end
    end

    // State, counters and registered outputs; reset clears outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            n_q      <= '0;
            m_q      <= '0;
            inst_v_q <= 1'b0;
            inst_q   <= '0;
            data_v_q <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            n_q      <= n_d;
            m_q      <= m_d;
            inst_v_q <= inst_v_d;
            inst_q   <= inst_d;
            data_v_q <= data_v_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign inst_out_v = inst_v_q;
    assign inst_out   = inst_q;
    assign dout_pe_v  = data_v_q;
    assign dout_pe    = data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pe_loader.sv
// Scoreboard bench for pe_loader: a sequence-level model predicts the per-cycle
// output trace at each accepted start; a monitor compares every cycle.
module tb_pe_loader;

    localparam int ID  = 8;
    localparam int DD  = 16;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_wr_en = 1'b0;
    logic [2:0]  inst_wr_addr = '0;
    logic [31:0] inst_wr_data = '0;
    logic        data_wr_en = 1'b0;
    logic [3:0]  data_wr_addr = '0;
    logic [31:0] data_wr_data = '0;
    logic        start = 1'b0;
    logic [3:0]  inst_cnt = '0;
    logic [4:0]  data_cnt = '0;
    logic        inst_out_v;
    logic [31:0] inst_out;
    logic        dout_pe_v;
    logic [31:0] dout_pe;
    logic        busy;
    logic        done;

    pe_loader #(
        .INST_DEPTH (ID),
        .DATA_DEPTH (DD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_wr_en   (inst_wr_en),
        .inst_wr_addr (inst_wr_addr),
        .inst_wr_data (inst_wr_data),
        .data_wr_en   (data_wr_en),
        .data_wr_addr (data_wr_addr),
        .data_wr_data (data_wr_data),
        .start        (start),
        .inst_cnt     (inst_cnt),
        .data_cnt     (data_cnt),
        .inst_out_v   (inst_out_v),
        .inst_out     (inst_out),
        .dout_pe_v    (dout_pe_v),
        .dout_pe      (dout_pe),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [31:0] i;
        logic        dv;
        logic [31:0] d;
        logic        busy;
        logic        done;
    } rec_t;

    rec_t        sb[$];
    logic [31:0] ibuf_m [ID];
    logic [31:0] dbuf_m [DD];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          e0 = 0;
    int          seq_len = 0;
    bit          active = 1'b0;
    bit          mon_en = 1'b0;

    function automatic rec_t dut_rec();
        rec_t r;
        r.iv   = inst_out_v;
        r.i    = inst_out;
        r.dv   = dout_pe_v;
        r.d    = dout_pe;
        r.busy = busy;
        r.done = done;
        return r;
    endfunction

    // Per-cycle trace check; an empty scoreboard means the loader must be silent.
    initial begin
        rec_t e, g;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                e = '0;
                if (sb.size() > 0) e = sb.pop_front();
                g = dut_rec();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL trace cyc=%0d got iv=%b i=%h dv=%b d=%h busy=%b done=%b exp iv=%b i=%h dv=%b d=%h busy=%b done=%b",
                             cyc, g.iv, g.i, g.dv, g.d, g.busy, g.done, e.iv, e.i, e.dv, e.d, e.busy, e.done);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        #2;
    endtask

    // Expected cycle trace for one accepted start, from the sequence rules.
    task automatic launch(input int ic, input int dc);
        int   n, m;
        rec_t r;
        n = (ic > ID) ? ID : ic;
        m = (dc > DD) ? DD : dc;
        for (int k = 0; k < n; k++) begin
            r = '0; r.iv = 1'b1; r.i = ibuf_m[k]; r.busy = 1'b1;
            sb.push_back(r);
        end
        if (n > 0 && m > 0) begin
            for (int g = 0; g < GAP; g++) begin
                r = '0; r.busy = 1'b1;
                sb.push_back(r);
            end
        end
        for (int j = 0; j < m; j++) begin
            r = '0; r.dv = 1'b1; r.d = dbuf_m[j]; r.busy = 1'b1;
            sb.push_back(r);
        end
        r = '0; r.done = 1'b1;
        sb.push_back(r);
        seq_len = n + ((n > 0 && m > 0) ? GAP : 0) + m + 1;
        e0 = cyc;
        active = 1'b1;
    endtask

    function automatic bit in_seq();
        return active && ((cyc - e0) <= seq_len - 1);
    endfunction

    function automatic bit busy_now();
        return active && ((cyc - e0) <= seq_len - 2);
    endfunction

    // One clock of host activity; the model decides whether writes/start are honoured.
    task automatic step(input bit iw, input int ia, input logic [31:0] idat,
                        input bit dw, input int da, input logic [31:0] ddat,
                        input bit st, input int ic, input int dc);
        bit acc_w, acc_s;
        ic = ic & 15;
        dc = dc & 31;
        inst_wr_en = iw; inst_wr_addr = ia[2:0]; inst_wr_data = idat;
        data_wr_en = dw; data_wr_addr = da[3:0]; data_wr_data = ddat;
        start = st; inst_cnt = ic[3:0]; data_cnt = dc[4:0];
        if (active && !in_seq()) active = 1'b0;
        acc_w = !busy_now();
        acc_s = !in_seq();
        if (iw && acc_w) ibuf_m[ia & 7] = idat;
        if (dw && acc_w) dbuf_m[da & 15] = ddat;
        tick();
        if (st && acc_s) launch(ic, dc);
        inst_wr_en = 1'b0; data_wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic wait_seq();
        for (int w = 0; w < 200 && in_seq(); w++) idle(1);
        idle(1);
    endtask

    task automatic chk_quiet(input string name);
        rec_t g;
        g = dut_rec();
        checks++;
        if (g !== rec_t'(0)) begin
            errors++;
            $display("FAIL %s got iv=%b i=%h dv=%b d=%h busy=%b done=%b exp all zero",
                     name, g.iv, g.i, g.dv, g.d, g.busy, g.done);
        end
    endtask

    initial begin
        logic [31:0] ivals [3];
        logic [31:0] dvals [6];
        logic [31:0] old0;
        ivals[0] = 32'h80010080; ivals[1] = 32'h80030281; ivals[2] = 32'h80050482;
        dvals[0] = 32'h00040002; dvals[1] = 32'h00030001; dvals[2] = 32'h00080006;
        dvals[3] = 32'h00070005; dvals[4] = 32'h000C000A; dvals[5] = 32'h000B0009;

        #1;
        chk_quiet("reset_state");
        tick(); tick();
        rst = 1'b0;
        mon_en = 1'b1;

        for (int a = 0; a < ID; a++) step(1, a, $urandom, 0, 0, '0, 0, 0, 0);
        for (int a = 0; a < DD; a++) step(0, 0, '0, 1, a, $urandom, 0, 0, 0);

        // basic sequence
        for (int a = 0; a < 3; a++) step(1, a, ivals[a], 0, 0, '0, 0, 0, 0);
        for (int a = 0; a < 6; a++) step(0, 0, '0, 1, a, dvals[a], 0, 0, 0);
        step(0, 0, '0, 0, 0, '0, 1, 3, 6);
        wait_seq();

        // zero counts, then instructions only
        step(0, 0, '0, 0, 0, '0, 1, 0, 0);
        wait_seq();
        step(0, 0, '0, 0, 0, '0, 1, 2, 0);
        wait_seq();

        // write and restart while busy are dropped; readback shows old ibuf[0]
        old0 = ibuf_m[0];
        step(0, 0, '0, 0, 0, '0, 1, 3, 6);
        idle(2);
        step(1, 0, ~old0, 0, 0, '0, 1, 5, 5);
        idle(3);
        step(0, 0, '0, 1, 0, 32'h12345678, 1, 1, 1);
        wait_seq();
        step(0, 0, '0, 0, 0, '0, 1, 1, 0);
        wait_seq();

        // reset during DATA at j=3, then full replay
        step(0, 0, '0, 0, 0, '0, 1, 3, 6);
        idle(8);
        rst = 1'b1;
        #1;
        chk_quiet("async_reset");
        sb.delete();
        active = 1'b0;
        tick();
        rst = 1'b0;
        idle(3);
        step(0, 0, '0, 0, 0, '0, 1, 3, 6);
        wait_seq();

        // clamping and write coincident with start
        step(0, 0, '0, 0, 0, '0, 1, 9, 0);
        wait_seq();
        step(1, 0, 32'hCAFE0001, 1, 0, 32'hBEEF0002, 1, 1, 31);
        wait_seq();

        // randomized runs with interfering host traffic
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 1) == 1)
                step(1, $urandom_range(0, 7), $urandom, 1, $urandom_range(0, 15), $urandom, 0, 0, 0);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom,
                 1, $urandom_range(0, 15), $urandom_range(0, 31));
            for (int w = 0; w < 200 && in_seq(); w++)
                step($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 15), $urandom_range(0, 31));
            idle($urandom_range(0, 2));
        end

        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries exp 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_loader.md
Name: pe_loader

Overview:
- Initiator side of the PE load interface: it drives the same instruction and data streams that a `pe` instance consumes on `inst_in_v`/`inst_in` and `din_pe_v`/`din_pe`.
- A host preloads a small instruction buffer and a small complex-data buffer, then pulses `start`.
- `pe_loader` then streams the instructions back-to-back, idles for a fixed gap, and streams the data words back-to-back.
- It sits between the host/control logic and one PE in the array.

Parameters:
- INST_DEPTH, 8, instruction buffer entries (power of 2, at least 2).
- DATA_DEPTH, 16, data buffer entries (power of 2, at least 2).
- GAP_CYCLES, 2, idle cycles between the last instruction and the first data word (0 allowed).
- IAW, $clog2(INST_DEPTH), instruction address width.
- DAW, $clog2(DATA_DEPTH), data address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- inst_wr_en  in  1  instruction buffer write strobe.
- inst_wr_addr  in  IAW  instruction buffer write address.
- inst_wr_data  in  `INST_WIDTH  instruction word.
- data_wr_en  in  1  data buffer write strobe.
- data_wr_addr  in  DAW  data buffer write address.
- data_wr_data  in  `DATA_WIDTH*2  complex word: real part in [31:16], imaginary part in [15:0].
- start  in  1  launch request, sampled only in IDLE.
- inst_cnt  in  IAW+1  number of instructions to send, sampled with start.
- data_cnt  in  DAW+1  number of data words to send, sampled with start.
- inst_out_v  out  1  instruction valid, connects to pe.inst_in_v.
- inst_out  out  `INST_WIDTH  connects to pe.inst_in.
- dout_pe_v  out  1  data valid, connects to pe.din_pe_v.
- dout_pe  out  `DATA_WIDTH*2  connects to pe.din_pe.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle pulse at the end of a sequence.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the counters are 0. Buffer contents are not reset.
- All outputs are registered. When a valid is low, its paired payload is driven to 0, never X.
- FSM states are IDLE, INST, GAP, DATA, FIN.
- Buffer writes:
  - Writes complete in one cycle and are accepted only when busy=0.
  - While busy=1, writes are silently dropped.
- Counts: `inst_cnt` and `data_cnt` are latched at the start edge and clamped to INST_DEPTH and DATA_DEPTH respectively.
- Timing, with E0 the edge where start=1 is sampled in IDLE, N the clamped instruction count and M the clamped data count:
  - busy=1 from after E0 through the last data cycle.
  - After edge E0+k, for k=0..N-1: inst_out_v=1 and inst_out=ibuf[k].
  - Then GAP_CYCLES cycles with both valids low.
  - After edge E0+N+GAP_CYCLES+j, for j=0..M-1: dout_pe_v=1 and dout_pe=dbuf[j].
  - The next edge enters FIN: all valids 0, busy=0, done=1 for exactly one cycle, then IDLE.
- Phase skipping:
  - N=0: skip INST and GAP.
  - M=0: skip GAP and DATA.
  - N=0 and M=0: done pulses after E0 with no valid ever asserted.
- start while busy or in FIN is ignored, with no queuing. start in the same cycle as a buffer write: the write lands first, and the streamed sequence sees the new value.
- inst_out_v and dout_pe_v are never high in the same cycle.
- Reset asserted mid-sequence: outputs clear immediately (asynchronously), the sequence is abandoned, and no done pulse is produced.

Decomposition:
- `parameters.vh` provides `DATA_WIDTH` (16) and `INST_WIDTH` (32).
- FSM state encodings are localparams inside pe_loader.
- One sub-module, pe_loader_buf: a parameterized (WIDTH, DEPTH) register file with synchronous write and combinational read, with no reset on storage. It is instantiated twice, once for instructions and once for data.

Test Plan:
- Basic sequence:
  - Stimulus: write ibuf = {32'h80010080, 32'h80030281, 32'h80050482} and dbuf = {0x00040002, 0x00030001, 0x00080006, 0x00070005, 0x000C000A, 0x000B0009}; start with inst_cnt=3, data_cnt=6.
  - Required: 3 consecutive inst_out_v cycles in that order, 2 idle cycles, 6 consecutive dout_pe_v cycles in that order, then a single done pulse; busy high for 11 cycles.
- Zero counts: start with inst_cnt=0, data_cnt=0 → done after one cycle, inst_out_v and dout_pe_v stay 0, busy never high beyond E0.
- Instructions only: inst_cnt=2, data_cnt=0 → two instruction words, then done immediately with no gap cycles.
- Writes and start during busy: a write to ibuf[0] and a second start issued mid-sequence → the stream is unchanged, no second sequence runs, and a later readback stream shows the old ibuf[0].
- Reset mid-operation: assert rst during the DATA phase at j=3 → outputs become 0 within the reset cycle, no done pulse; a new start after reset replays the full sequence correctly.
- Clamping: with INST_DEPTH=8, inst_cnt=9 → exactly 8 instructions sent, ibuf[0..7].
